// File: rtl/fault_mem_cfg_if.sv
// Access and fault-configuration bus of fault_mem_cfg.
// No valid/ready: every clock is a command. write_read=1 stores the wdata presented one cycle earlier; write_read=0 reads and rdata follows two clocks later. cfg_we loads one fault slot.
interface fault_mem_cfg_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  localparam int BIT_W = $clog2(DATA_WIDTH);

  logic                  write_read;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  cfg_we;
  logic [2:0]            cfg_slot;
  logic [2:0]            cfg_type;
  logic [ADDR_WIDTH-1:0] cfg_vaddr;
  logic [BIT_W-1:0]      cfg_vbit;
  logic [ADDR_WIDTH-1:0] cfg_aaddr;
  logic [BIT_W-1:0]      cfg_abit;
  logic                  fault_hit;
  logic [15:0]           hit_cnt;

  modport master (
    output write_read, address, wdata, cfg_we, cfg_slot, cfg_type,
           cfg_vaddr, cfg_vbit, cfg_aaddr, cfg_abit,
    input  rdata, fault_hit, hit_cnt
  );

  modport slave (
    input  write_read, address, wdata, cfg_we, cfg_slot, cfg_type,
           cfg_vaddr, cfg_vbit, cfg_aaddr, cfg_abit,
    output rdata, fault_hit, hit_cnt
  );
endinterface

// File: rtl/fault_mem_cfg.sv
// Single-port behavioural memory with NUM_FAULTS runtime-programmable fault slots.
// Define FAULT_MEM_HIT_CNT_EN to enable the saturating activation counter on hit_cnt.
module fault_mem_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 16,
  parameter int NUM_FAULTS = 2
) (
  input logic            clk,
  input logic            rst_n,
  fault_mem_cfg_if.slave bus
);
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0] CAP = (ADDR_WIDTH+1)'(CAPACITY);
  localparam logic [BIT_W:0]      DW  = (BIT_W+1)'(DATA_WIDTH);

  typedef enum logic [2:0] {
    F_NONE = 3'd0, F_SA0 = 3'd1, F_SA1 = 3'd2, F_TF_UP = 3'd3,
    F_TF_DN = 3'd4, F_CFID = 3'd5, F_NPSF = 3'd6
  } fault_e;

  logic [DATA_WIDTH-1:0] mem [CAPACITY];
  logic [DATA_WIDTH-1:0] wdata_d, stage1;
  fault_e                slot_type  [NUM_FAULTS];
  logic [ADDR_WIDTH-1:0] slot_vaddr [NUM_FAULTS];
  logic [ADDR_WIDTH-1:0] slot_aaddr [NUM_FAULTS];
  logic [BIT_W-1:0]      slot_vbit  [NUM_FAULTS];
  logic [BIT_W-1:0]      slot_abit  [NUM_FAULTS];

  logic                  in_range, hit_now, hit_q;
  logic [DATA_WIDTH-1:0] old_word, wr_word, rd_word;
  logic [NUM_FAULTS-1:0] cf_set;
  logic [ADDR_WIDTH:0]   n_up, n_dn;
  logic [BIT_W:0]        b_up, b_dn;
  logic [3:0]            pattern;

  // Slots are applied in ascending order, so a later slot overrides an earlier one on the same bit.
  always_comb begin
    in_range = {1'b0, bus.address} < CAP;
    old_word = in_range ? mem[bus.address] : '0;
    wr_word  = wdata_d;
    rd_word  = old_word;
    cf_set   = '0;
    n_up     = '0;
    n_dn     = '0;
    b_up     = '0;
    b_dn     = '0;
    pattern  = '0;
    for (int i = 0; i < NUM_FAULTS; i++) begin
      if (slot_vaddr[i] == bus.address) begin
        case (slot_type[i])
          F_SA0: begin
            wr_word[slot_vbit[i]] = 1'b0;
            rd_word[slot_vbit[i]] = 1'b0;
          end
          F_SA1: begin
            wr_word[slot_vbit[i]] = 1'b1;
            rd_word[slot_vbit[i]] = 1'b1;
          end
          F_TF_UP: if (!old_word[slot_vbit[i]] && wr_word[slot_vbit[i]]) wr_word[slot_vbit[i]] = 1'b0;
          F_TF_DN: if (old_word[slot_vbit[i]] && !wr_word[slot_vbit[i]]) wr_word[slot_vbit[i]] = 1'b1;
          F_NPSF: begin
            // Neighbours outside the array or word wrap to large values and read as 0.
            n_up = {1'b0, slot_vaddr[i]} + (ADDR_WIDTH+1)'(1);
            n_dn = {1'b0, slot_vaddr[i]} - (ADDR_WIDTH+1)'(1);
            b_up = {1'b0, slot_vbit[i]} + (BIT_W+1)'(1);
            b_dn = {1'b0, slot_vbit[i]} - (BIT_W+1)'(1);
            pattern[3] = (n_up < CAP) && mem[n_up[ADDR_WIDTH-1:0]][slot_vbit[i]];
            pattern[2] = (n_dn < CAP) && mem[n_dn[ADDR_WIDTH-1:0]][slot_vbit[i]];
            pattern[1] = (b_up < DW) && old_word[b_up[BIT_W-1:0]];
            pattern[0] = (b_dn < DW) && old_word[b_dn[BIT_W-1:0]];
            if (pattern == 4'b1110) wr_word[slot_vbit[i]] = 1'b1;
          end
          default: ;
        endcase
      end
      if (slot_type[i] == F_CFID && slot_aaddr[i] == bus.address &&
          !old_word[slot_abit[i]] && wr_word[slot_abit[i]]) begin
        if (slot_vaddr[i] == slot_aaddr[i]) wr_word[slot_vbit[i]] = 1'b1;
        else if ({1'b0, slot_vaddr[i]} < CAP) cf_set[i] = 1'b1;
      end
    end
    hit_now = in_range && (bus.write_read ? ((wr_word != wdata_d) || (|cf_set))
                                          : (rd_word != old_word));
  end

  always_ff @(posedge clk) begin
    if (bus.write_read && in_range) begin
      mem[bus.address] <= wr_word;
      for (int i = 0; i < NUM_FAULTS; i++)
        if (cf_set[i]) mem[slot_vaddr[i]][slot_vbit[i]] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdata_d       <= '0;
      stage1        <= '0;
      bus.rdata     <= '0;
      hit_q         <= 1'b0;
      bus.fault_hit <= 1'b0;
      for (int i = 0; i < NUM_FAULTS; i++) begin
        slot_type[i]  <= F_NONE;
        slot_vaddr[i] <= '0;
        slot_aaddr[i] <= '0;
        slot_vbit[i]  <= '0;
        slot_abit[i]  <= '0;
      end
    end else begin
      wdata_d <= bus.wdata;
      if (!bus.write_read) stage1 <= rd_word;
      bus.rdata     <= stage1;
      hit_q         <= hit_now;
      bus.fault_hit <= hit_q;
      for (int i = 0; i < NUM_FAULTS; i++) begin
        if (bus.cfg_we && bus.cfg_slot == 3'(i)) begin
          slot_type[i]  <= fault_e'(bus.cfg_type);
          slot_vaddr[i] <= bus.cfg_vaddr;
          slot_vbit[i]  <= bus.cfg_vbit;
          slot_aaddr[i] <= bus.cfg_aaddr;
          slot_abit[i]  <= bus.cfg_abit;
        end
      end
    end
  end

`ifdef FAULT_MEM_HIT_CNT_EN
  logic [15:0] hit_cnt_r;
  // Counts alongside fault_hit so the count already includes the pulse being shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit_cnt_r <= '0;
    else if (hit_q && hit_cnt_r != 16'hFFFF) hit_cnt_r <= hit_cnt_r + 16'd1;
  end
  assign bus.hit_cnt = hit_cnt_r;
`else
  assign bus.hit_cnt = '0;
`endif
endmodule

// File: tb/tb_fault_mem_cfg.sv
// Randomised and directed bench for fault_mem_cfg against a rule-level memory/fault model.
module tb_fault_mem_cfg;
  localparam int DW = 8, AW = 4, CAP = 16, NF = 2, IDLE = 15;
`ifdef FAULT_MEM_HIT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fault_mem_cfg_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
  fault_mem_cfg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP), .NUM_FAULTS(NF))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: memory contents, slot table, and timed expectations
  logic [DW-1:0] m [CAP];
  int s_type [NF], s_va [NF], s_vb [NF], s_aa [NF], s_ab [NF];
  logic [DW-1:0] prev_wdata;
  logic [DW-1:0] exp_q [$];
  int            due_q [$];
  int            hit_due [$];
  logic [DW-1:0] exp_rdata;
  bit            exp_hit;
  int            exp_cnt;
  int            cyc = 0;

  function automatic bit mbit(input int a, input int b);
    if (a < 0 || a >= CAP || b < 0 || b >= DW) return 1'b0;
    return m[a][b];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      s_type[i] = 0; s_va[i] = 0; s_vb[i] = 0; s_aa[i] = 0; s_ab[i] = 0;
    end
    prev_wdata = '0;
    exp_q.delete(); due_q.delete(); hit_due.delete();
    exp_rdata = '0; exp_hit = 1'b0; exp_cnt = 0;
  endtask

  // One clock: predict the edge from current inputs, advance, then compare outputs.
  task automatic tick();
    int a;
    bit is_wr, hit;
    logic [DW-1:0] w, r, old;
    int cf_a [$];
    int cf_b [$];
    a = int'(bus.address);
    is_wr = bus.write_read;
    hit = 1'b0;
    w = prev_wdata;
    if (a < CAP) begin
      old = m[a];
      if (is_wr) begin
        for (int i = 0; i < NF; i++) begin
          int b = s_vb[i];
          if (s_va[i] == a) begin
            case (s_type[i])
              1: w[b] = 1'b0;
              2: w[b] = 1'b1;
              3: if (old[b] == 1'b0 && w[b] == 1'b1) w[b] = 1'b0;
              4: if (old[b] == 1'b1 && w[b] == 1'b0) w[b] = 1'b1;
              6: if ({mbit(a + 1, b), mbit(a - 1, b), mbit(a, b + 1), mbit(a, b - 1)} == 4'b1110)
                   w[b] = 1'b1;
              default: ;
            endcase
          end
          if (s_type[i] == 5 && s_aa[i] == a && old[s_ab[i]] == 1'b0 && w[s_ab[i]] == 1'b1) begin
            if (s_va[i] == a) w[b] = 1'b1;
            else begin cf_a.push_back(s_va[i]); cf_b.push_back(b); end
          end
        end
        hit = (w != prev_wdata) || (cf_a.size() > 0);
      end else begin
        r = old;
        for (int i = 0; i < NF; i++)
          if (s_va[i] == a && (s_type[i] == 1 || s_type[i] == 2)) r[s_vb[i]] = (s_type[i] == 2);
        hit = (r != old);
        exp_q.push_back(r); due_q.push_back(cyc + 2);
      end
    end else if (!is_wr) begin
      exp_q.push_back('0); due_q.push_back(cyc + 2);
    end
    if (hit) hit_due.push_back(cyc + 2);
    if (bus.cfg_we && int'(bus.cfg_slot) < NF) begin
      int k = int'(bus.cfg_slot);
      s_type[k] = int'(bus.cfg_type); s_va[k] = int'(bus.cfg_vaddr); s_vb[k] = int'(bus.cfg_vbit);
      s_aa[k] = int'(bus.cfg_aaddr); s_ab[k] = int'(bus.cfg_abit);
    end
    prev_wdata = bus.wdata;
    @(posedge clk);
    if (is_wr && a < CAP) begin
      m[a] = w;
      foreach (cf_a[k]) m[cf_a[k]][cf_b[k]] = 1'b1;
    end
    cyc++;
    #1;
    while (due_q.size() > 0 && due_q[0] == cyc) begin
      exp_rdata = exp_q.pop_front();
      void'(due_q.pop_front());
    end
    exp_hit = (hit_due.size() > 0 && hit_due[0] == cyc);
    if (exp_hit) begin
      void'(hit_due.pop_front());
      if (exp_cnt < 65535) exp_cnt++;
    end
    if (!$isunknown(exp_rdata)) check_eq("rdata", bus.rdata, exp_rdata);
    check_eq("fault_hit", bus.fault_hit, exp_hit);
    check_eq("hit_cnt", bus.hit_cnt, CNT_EN ? 16'(exp_cnt) : 16'h0);
    bus.cfg_we = 1'b0;
  endtask

  // driver tasks
  task automatic idle();
    bus.write_read = 1'b0; bus.address = AW'(IDLE);
    tick();
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    bus.write_read = 1'b0; bus.address = AW'(IDLE); bus.wdata = d;
    tick();
    bus.write_read = 1'b1; bus.address = AW'(a);
    tick();
  endtask

  // ewh: pulse expected from the preceding access; erh: pulse expected from this read.
  task automatic rd_expect(input string tag, input int a, input logic [DW-1:0] ev,
                           input bit ewh, input bit erh);
    bus.write_read = 1'b0; bus.address = AW'(a);
    tick();
    check_eq({tag, "_prev_hit"}, bus.fault_hit, ewh);
    bus.address = AW'(IDLE);
    tick();
    check_eq(tag, bus.rdata, ev);
    check_eq({tag, "_hit"}, bus.fault_hit, erh);
  endtask

  task automatic set_cfg(input int slot, input int t, input int va, input int vb,
                         input int aa, input int ab);
    bus.cfg_we = 1'b1; bus.cfg_slot = 3'(slot); bus.cfg_type = 3'(t);
    bus.cfg_vaddr = AW'(va); bus.cfg_vbit = 3'(vb); bus.cfg_aaddr = AW'(aa); bus.cfg_abit = 3'(ab);
  endtask

  task automatic cfg(input int slot, input int t, input int va, input int vb,
                     input int aa, input int ab);
    set_cfg(slot, t, va, vb, aa, ab);
    idle();
  endtask

  task automatic do_reset();
    bus.write_read = 1'b0; bus.cfg_we = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_rdata", bus.rdata, 16'h0);
    check_eq("rst_fault_hit", bus.fault_hit, 16'h0);
    check_eq("rst_hit_cnt", bus.hit_cnt, 16'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.write_read = 1'b0; bus.address = AW'(IDLE); bus.wdata = '0;
    set_cfg(0, 0, 0, 0, 0, 0);
    bus.cfg_we = 1'b0;
    for (int a = 0; a < CAP; a++) m[a] = 'x;
    model_reset();
    do_reset();

    for (int a = 0; a < CAP; a++) wr(a, (a == 3) ? 8'hA5 : 8'($urandom_range(0, 255)));

    // slot cleared by a reset arriving mid-read
    cfg(0, 1, 3, 0, 0, 0);
    rd_expect("sa0_pre_reset", 3, 8'hA4, 1'b0, 1'b1);
    bus.write_read = 1'b0; bus.address = AW'(3);
    tick();
    do_reset();
    rd_expect("post_reset", 3, 8'hA5, 1'b0, 1'b0);

    // stuck-at-1, plus a slot cleared in the same cycle as a read
    cfg(0, 2, 5, 2, 0, 0);
    wr(5, 8'h00);
    rd_expect("sa1", 5, 8'h04, 1'b1, 1'b0);
    wr(6, 8'h00);
    rd_expect("sa1_other", 6, 8'h00, 1'b0, 1'b0);
    cfg(0, 1, 5, 2, 0, 0);
    set_cfg(0, 0, 0, 0, 0, 0);
    rd_expect("cfg_same_cycle", 5, 8'h00, 1'b0, 1'b1);
    rd_expect("cfg_cleared", 5, 8'h04, 1'b0, 1'b0);

    // transition fault up
    cfg(0, 3, 2, 7, 0, 0);
    wr(2, 8'h00);
    wr(2, 8'hFF);
    rd_expect("tf_up", 2, 8'h7F, 1'b1, 1'b0);
    cfg(0, 0, 0, 0, 0, 0);
    wr(2, 8'h80);
    rd_expect("tf_cleared", 2, 8'h80, 1'b0, 1'b0);

    // idempotent coupling fault
    cfg(1, 5, 9, 3, 1, 0);
    wr(9, 8'h00);
    wr(1, 8'h00);
    wr(1, 8'h01);
    rd_expect("cfid_victim", 9, 8'h08, 1'b1, 1'b0);
    rd_expect("cfid_aggr", 1, 8'h01, 1'b0, 1'b0);
    cfg(1, 0, 0, 0, 0, 0);

    // neighbourhood pattern sensitive fault, interior and edge victim
    wr(8, 8'h20);
    wr(6, 8'h20);
    wr(7, 8'h40);
    cfg(0, 6, 7, 5, 0, 0);
    wr(7, 8'h40);
    rd_expect("npsf", 7, 8'h60, 1'b1, 1'b0);
    cfg(0, 6, 0, 5, 0, 0);
    wr(1, 8'h20);
    wr(0, 8'h40);
    wr(0, 8'h40);
    rd_expect("npsf_edge", 0, 8'h40, 1'b0, 1'b0);

    // two slots on one bit: the higher slot wins
    cfg(0, 1, 4, 1, 0, 0);
    cfg(1, 2, 4, 1, 0, 0);
    wr(4, 8'h00);
    rd_expect("two_slots", 4, 8'h02, 1'b1, 1'b0);
    cfg(0, 0, 0, 0, 0, 0);
    cfg(1, 0, 0, 0, 0, 0);

    // random traffic with random slot programming
    for (int n = 0; n < 600; n++) begin
      bus.write_read = 1'($urandom_range(0, 1));
      bus.address    = AW'($urandom_range(0, CAP - 1));
      bus.wdata      = DW'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0)
        set_cfg($urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, CAP - 1),
                $urandom_range(0, DW - 1), $urandom_range(0, CAP - 1), $urandom_range(0, DW - 1));
      tick();
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
